gshare_btb_predictor: RTL and testbench

//  Parametrised gshare direction predictor plus direct-mapped BTB, shared by FE (lookup) and AGEX (resolve/update).
//  - Sizes of BHR, pattern table, BTB and counters are parameters instead of fixed macros.
//  - Owns its own table-clearing FSM after reset.
//  - Keeps resolve statistics.
//  - Lookup indices are returned to FE so they can travel down the pipe and come back on update.

---
 rtl/gshare_btb_predictor_pkg.sv | 30 +++
 rtl/gshare_btb_predictor_sat_counter_update.sv | 22 ++
 rtl/gshare_btb_predictor.sv | 177 +++++++++++++++++
 tb/tb_gshare_btb_predictor.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gshare_btb_predictor_pkg.sv
// Shared types, default sizes and counter helpers for the gshare/BTB predictor.
package gshare_btb_predictor_pkg;

  // Controller states: table clearing after reset, then normal operation.
  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } pred_state_e;

  // Width of the resolve statistics counters.
  localparam int STAT_BITS = 32;

  // Default sizes; these also set the widths of the lk_* fields that ride
  // through the FE->DE->AGEX latches and come back as up_*.
  localparam int DEF_DBITS        = 32;
  localparam int DEF_BHR_BITS     = 8;
  localparam int DEF_PT_IDX_BITS  = 8;
  localparam int DEF_BTB_IDX_BITS = 6;
  localparam int DEF_CTR_BITS     = 2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Weakly-not-taken value: the largest value whose MSB is still clear.
  function automatic int ctr_weak_nt(input int ctr_bits);
    return (1 << (ctr_bits - 1)) - 1;
  endfunction

endpackage

// File: rtl/gshare_btb_predictor_sat_counter_update.sv
// Next-value logic for a saturating up/down counter (no wrap at either end).
module sat_counter_update
  import gshare_btb_predictor_pkg::*;
#(
  parameter int CTR_BITS = DEF_CTR_BITS
) (
  input  logic [CTR_BITS-1:0] ctr_cur,
  input  logic                inc,
  output logic [CTR_BITS-1:0] ctr_next
);

  // Step toward the requested end, holding once the end is reached.
  always_comb begin
    ctr_next = ctr_cur;
    if (inc) begin
      if (ctr_cur != '1) ctr_next = ctr_cur + CTR_BITS'(1);
    end else begin
      if (ctr_cur != '0) ctr_next = ctr_cur - CTR_BITS'(1);
    end
  end

endmodule

// File: rtl/gshare_btb_predictor.sv
// Gshare direction predictor plus direct-mapped BTB. FE looks up
// combinationally; AGEX resolves and updates at the clock edge. After reset
// the block clears its own tables before raising ready.
module gshare_btb_predictor
  import gshare_btb_predictor_pkg::*;
#(
  parameter int DBITS        = DEF_DBITS,
  parameter int BHR_BITS     = DEF_BHR_BITS,
  parameter int PT_IDX_BITS  = DEF_PT_IDX_BITS,
  parameter int BTB_IDX_BITS = DEF_BTB_IDX_BITS,
  parameter int CTR_BITS     = DEF_CTR_BITS
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic                    ready,
  input  logic [DBITS-1:0]        lk_pc,
  output logic                    lk_taken,
  output logic                    lk_hit,
  output logic [DBITS-1:0]        lk_target,
  output logic [PT_IDX_BITS-1:0]  lk_pt_idx,
  output logic [BTB_IDX_BITS-1:0] lk_btb_idx,
  input  logic                    up_valid,
  input  logic                    up_is_cond,
  input  logic [DBITS-1:0]        up_pc,
  input  logic                    up_taken,
  input  logic [DBITS-1:0]        up_target,
  input  logic [PT_IDX_BITS-1:0]  up_pt_idx,
  input  logic [BTB_IDX_BITS-1:0] up_btb_idx,
  input  logic                    up_mispred,
  output logic [BHR_BITS-1:0]     bhr_out,
  output logic [STAT_BITS-1:0]    stat_updates,
  output logic [STAT_BITS-1:0]    stat_mispreds
);

  localparam int TAG_BITS    = DBITS - BTB_IDX_BITS - 2;
  localparam int INIT_BITS   = max_int(PT_IDX_BITS, BTB_IDX_BITS);
  localparam int PT_ENTRIES  = 1 << PT_IDX_BITS;
  localparam int BTB_ENTRIES = 1 << BTB_IDX_BITS;
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(ctr_weak_nt(CTR_BITS));

  // Tables
  logic [CTR_BITS-1:0] pt_mem         [PT_ENTRIES];
  logic                btb_valid_mem  [BTB_ENTRIES];
  logic [TAG_BITS-1:0] btb_tag_mem    [BTB_ENTRIES];
  logic [DBITS-1:0]    btb_target_mem [BTB_ENTRIES];

  // Control and architectural state
  pred_state_e            state_reg, state_next;
  logic [INIT_BITS-1:0]   init_idx_reg, init_idx_next;
  logic [BHR_BITS-1:0]    bhr_reg;
  logic [STAT_BITS-1:0]   stat_updates_reg, stat_mispreds_reg;

  logic                   in_run;
  logic                   up_accept;
  logic                   init_pt_en, init_btb_en;
  logic                   pt_init_we, btb_init_we;
  logic [CTR_BITS-1:0]    pt_ctr_next;
  logic [BHR_BITS:0]      bhr_shifted;
  logic [TAG_BITS-1:0]    lk_tag;
  logic                   lk_tag_match;
  logic                   unused_bits;

  assign in_run    = (state_reg == ST_RUN);
  assign up_accept = in_run && up_valid && !reset;

  // Only part of the clearing sweep addresses the smaller table.
  if (PT_IDX_BITS < INIT_BITS) begin : g_pt_short
    assign init_pt_en = ~|init_idx_reg[INIT_BITS-1:PT_IDX_BITS];
  end else begin : g_pt_full
    assign init_pt_en = 1'b1;
  end

  if (BTB_IDX_BITS < INIT_BITS) begin : g_btb_short
    assign init_btb_en = ~|init_idx_reg[INIT_BITS-1:BTB_IDX_BITS];
  end else begin : g_btb_full
    assign init_btb_en = 1'b1;
  end

  assign pt_init_we  = (state_reg == ST_INIT) && !reset && init_pt_en;
  assign btb_init_we = (state_reg == ST_INIT) && !reset && init_btb_en;

  // Controller state register; reset always restarts the clearing sweep.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_INIT;
      init_idx_reg <= '0;
    end else begin
      state_reg    <= state_next;
      init_idx_reg <= init_idx_next;
    end
  end

  // Sweep every index of the larger table once, then stay in RUN.
  always_comb begin
    state_next    = state_reg;
    init_idx_next = init_idx_reg;
    case (state_reg)
      ST_INIT: begin
        init_idx_next = init_idx_reg + INIT_BITS'(1);
        if (&init_idx_reg) state_next = ST_RUN;
      end
      ST_RUN: begin
        state_next = ST_RUN;
      end
      default: begin
        state_next    = ST_INIT;
        init_idx_next = '0;
      end
    endcase
  end

  sat_counter_update #(
    .CTR_BITS (CTR_BITS)
  ) u_sat_counter_update (
    .ctr_cur  (pt_mem[up_pt_idx]),
    .inc      (up_taken),
    .ctr_next (pt_ctr_next)
  );

  // Pattern table: cleared to weak-not-taken, trained by conditional branches.
  always_ff @(posedge clk) begin
    if (pt_init_we) begin
      pt_mem[init_idx_reg[PT_IDX_BITS-1:0]] <= CTR_INIT;
    end else if (up_accept && up_is_cond) begin
      pt_mem[up_pt_idx] <= pt_ctr_next;
    end
  end

  // BTB: invalidated during the sweep, filled by every taken branch or jump.
  always_ff @(posedge clk) begin
    if (btb_init_we) begin
      btb_valid_mem[init_idx_reg[BTB_IDX_BITS-1:0]]  <= 1'b0;
      btb_tag_mem[init_idx_reg[BTB_IDX_BITS-1:0]]    <= '0;
      btb_target_mem[init_idx_reg[BTB_IDX_BITS-1:0]] <= '0;
    end else if (up_accept && up_taken) begin
      btb_valid_mem[up_btb_idx]  <= 1'b1;
      btb_tag_mem[up_btb_idx]    <= up_pc[DBITS-1:BTB_IDX_BITS+2];
      btb_target_mem[up_btb_idx] <= up_target;
    end
  end

  assign bhr_shifted = {bhr_reg, up_taken};

  // Global history and resolve statistics; both counters wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      bhr_reg           <= '0;
      stat_updates_reg  <= '0;
      stat_mispreds_reg <= '0;
    end else if (up_accept) begin
      if (up_is_cond) bhr_reg <= bhr_shifted[BHR_BITS-1:0];
      stat_updates_reg  <= stat_updates_reg + STAT_BITS'(1);
      stat_mispreds_reg <= stat_mispreds_reg + STAT_BITS'(up_mispred);
    end
  end

  assign lk_tag       = lk_pc[DBITS-1:BTB_IDX_BITS+2];
  assign lk_tag_match = btb_valid_mem[lk_btb_idx] && (btb_tag_mem[lk_btb_idx] == lk_tag);

  // Zero-latency lookup against the current (pre-update) tables and history.
  always_comb begin
    lk_btb_idx = lk_pc[BTB_IDX_BITS+1:2];
    lk_pt_idx  = lk_pc[PT_IDX_BITS+1:2] ^ PT_IDX_BITS'(bhr_reg);
    lk_hit     = in_run && lk_tag_match;
    lk_taken   = lk_hit && pt_mem[lk_pt_idx][CTR_BITS-1];
    lk_target  = lk_taken ? btb_target_mem[lk_btb_idx] : (lk_pc + DBITS'(4));
  end

  assign ready         = in_run;
  assign bhr_out       = bhr_reg;
  assign stat_updates  = stat_updates_reg;
  assign stat_mispreds = stat_mispreds_reg;

  // Bits that are deliberately ignored: byte offsets and the history overflow bit.
  assign unused_bits = ^{lk_pc[1:0], up_pc[BTB_IDX_BITS+1:0], bhr_shifted[BHR_BITS]};

endmodule

// File: tb/tb_gshare_btb_predictor.sv
// Self-checking bench for gshare_btb_predictor (default parameters) against
// a behavioural model of the predictor's tables, history and statistics.
module tb_gshare_btb_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic        ready;
  logic [31:0] lk_pc;
  logic        lk_taken, lk_hit;
  logic [31:0] lk_target;
  logic [7:0]  lk_pt_idx;
  logic [5:0]  lk_btb_idx;
  logic        up_valid, up_is_cond, up_taken, up_mispred;
  logic [31:0] up_pc, up_target;
  logic [7:0]  up_pt_idx;
  logic [5:0]  up_btb_idx;
  logic [7:0]  bhr_out;
  logic [31:0] stat_updates, stat_mispreds;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: counters as plain integers, BTB as parallel arrays.
  int          pt_m [256];
  bit          btb_v_m [64];
  logic [23:0] btb_tag_m [64];
  logic [31:0] btb_t_m [64];
  int          bhr_m;
  logic [31:0] stat_u_m, stat_m_m;
  bit          ready_m;

  gshare_btb_predictor dut (
    .clk(clk), .reset(reset), .ready(ready),
    .lk_pc(lk_pc), .lk_taken(lk_taken), .lk_hit(lk_hit), .lk_target(lk_target),
    .lk_pt_idx(lk_pt_idx), .lk_btb_idx(lk_btb_idx),
    .up_valid(up_valid), .up_is_cond(up_is_cond), .up_pc(up_pc), .up_taken(up_taken),
    .up_target(up_target), .up_pt_idx(up_pt_idx), .up_btb_idx(up_btb_idx),
    .up_mispred(up_mispred), .bhr_out(bhr_out),
    .stat_updates(stat_updates), .stat_mispreds(stat_mispreds)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) pt_m[i] = 1;
    for (int i = 0; i < 64; i++) btb_v_m[i] = 1'b0;
    bhr_m = 0; stat_u_m = 0; stat_m_m = 0; ready_m = 1'b0;
  endtask

  task automatic drive_up(input bit cond, input logic [31:0] pc, input bit taken,
                          input logic [31:0] tgt, input int pidx, input bit mis);
    up_valid   = 1'b1;
    up_is_cond = cond;
    up_pc      = pc;
    up_taken   = taken;
    up_target  = tgt;
    up_pt_idx  = 8'(pidx);
    up_btb_idx = pc[7:2];
    up_mispred = mis;
  endtask

  // Clock the driven update in and apply the same resolve to the model.
  task automatic commit_up();
    int i;
    tick();
    up_valid = 1'b0;
    if (ready_m) begin
      i = int'(up_pt_idx);
      if (up_is_cond) begin
        if (up_taken) pt_m[i] = (pt_m[i] >= 3) ? 3 : pt_m[i] + 1;
        else          pt_m[i] = (pt_m[i] <= 0) ? 0 : pt_m[i] - 1;
        bhr_m = ((bhr_m << 1) | int'(up_taken)) & 255;
      end
      if (up_taken) begin
        btb_v_m[up_btb_idx]   = 1'b1;
        btb_tag_m[up_btb_idx] = up_pc[31:8];
        btb_t_m[up_btb_idx]   = up_target;
      end
      stat_u_m = stat_u_m + 1;
      if (up_mispred) stat_m_m = stat_m_m + 1;
    end
    $display("UPD ready=%0d cond=%0d pc=%h taken=%0d tgt=%h pt_idx=%h mis=%0d",
             ready_m, up_is_cond, up_pc, up_taken, up_target, up_pt_idx, up_mispred);
  endtask

  task automatic check_lookup(input logic [31:0] pc, input string name);
    int          idx, bi;
    bit          hit, tk;
    logic [31:0] tgt;
    lk_pc = pc;
    #1;
    idx = int'((pc >> 2) & 32'hFF) ^ bhr_m;
    bi  = int'((pc >> 2) & 32'h3F);
    hit = ready_m && btb_v_m[bi] && (btb_tag_m[bi] == pc[31:8]);
    tk  = hit && (pt_m[idx] >= 2);
    tgt = tk ? btb_t_m[bi] : pc + 32'd4;
    n_checks++;
    if (lk_taken !== tk || lk_hit !== hit || lk_target !== tgt ||
        lk_pt_idx !== 8'(idx) || lk_btb_idx !== 6'(bi)) begin
      n_errors++;
      $display("FAIL %s: pc=%h got taken=%b hit=%b tgt=%h pt=%h btb=%h, expected taken=%b hit=%b tgt=%h pt=%h btb=%h",
               name, pc, lk_taken, lk_hit, lk_target, lk_pt_idx, lk_btb_idx,
               tk, hit, tgt, 8'(idx), 6'(bi));
    end
  endtask

  task automatic check_state(input string name);
    n_checks++;
    if (ready !== ready_m || bhr_out !== 8'(bhr_m) ||
        stat_updates !== stat_u_m || stat_mispreds !== stat_m_m) begin
      n_errors++;
      $display("FAIL %s: got ready=%b bhr=%h upd=%0d mis=%0d, expected ready=%b bhr=%h upd=%0d mis=%0d",
               name, ready, bhr_out, stat_updates, stat_mispreds,
               ready_m, 8'(bhr_m), stat_u_m, stat_m_m);
    end
  endtask

  function automatic logic [31:0] pc_for_idx(input int idx, input logic [21:0] hi);
    logic [7:0] low;
    low = 8'(idx ^ bhr_m);
    return {hi, low, 2'b00};
  endfunction

  // Observe one pattern-table entry: install a BTB entry (via a jump, which
  // leaves PT and history alone) for a PC that hashes to idx, then look it up.
  task automatic probe(input int idx, input string name);
    logic [31:0] pc, tgt;
    pc  = pc_for_idx(idx, 22'($urandom));
    tgt = 32'($urandom) & 32'hFFFF_FFFC;
    drive_up(1'b0, pc, 1'b1, tgt, 0, 1'b0);
    commit_up();
    check_lookup(pc, name);
  endtask

  task automatic wait_ready(output int cnt, input bit drive_junk);
    cnt = 0;
    while (ready !== 1'b1 && cnt < 1000) begin
      if (drive_junk) begin
        drive_up(1'b1, 32'h0000_0200, 1'b1, 32'h0000_999C, $urandom_range(0, 255), 1'b1);
        commit_up();
      end else begin
        tick();
      end
      cnt++;
    end
  endtask

  task automatic test_reset();
    int cnt;
    reset = 1'b1;
    tick();
    model_reset();
    check_state("reset_state");
    reset = 1'b0;
    check_lookup(32'h0000_0100, "init_lookup");
    wait_ready(cnt, 1'b0);
    n_checks++;
    if (cnt != 256) begin
      n_errors++;
      $display("FAIL init_cycles: got %0d, expected 256", cnt);
    end
    ready_m = 1'b1;
    check_state("after_init");
    for (int i = 0; i < 4; i++) begin
      check_lookup(32'($urandom) & 32'hFFFF_FFFC, "after_init_lookup");
      tick();
    end
  endtask

  task automatic test_taken_branch();
    drive_up(1'b1, 32'h0000_0100, 1'b1, 32'h0000_0180, 8'h40, 1'b0);
    commit_up();
    drive_up(1'b1, 32'h0000_0100, 1'b1, 32'h0000_0180, 8'h40, 1'b1);
    commit_up();
    n_checks++;
    if (bhr_out !== 8'h03) begin
      n_errors++;
      $display("FAIL branch_bhr: got %h, expected 03", bhr_out);
    end
    lk_pc = 32'h0000_0100;
    #1;
    n_checks++;
    if ({lk_pt_idx, lk_hit, lk_taken, lk_target} !== {8'h43, 1'b1, 1'b0, 32'h0000_0104}) begin
      n_errors++;
      $display("FAIL branch_lookup: got idx=%h hit=%b taken=%b tgt=%h, expected idx=43 hit=1 taken=0 tgt=00000104",
               lk_pt_idx, lk_hit, lk_taken, lk_target);
    end
    check_state("branch_state");
    probe(8'h40, "branch_ctr_taken");
  endtask

  task automatic test_saturation();
    repeat (5) begin
      drive_up(1'b1, 32'h0000_3000, 1'b1, 32'h0000_3400, 8'h80, 1'b0);
      commit_up();
    end
    probe(8'h80, "sat_high");
    drive_up(1'b1, 32'h0000_3000, 1'b0, 32'h0000_3400, 8'h80, 1'b1);
    commit_up();
    probe(8'h80, "sat_high_dec");
    repeat (4) begin
      drive_up(1'b1, 32'h0000_3000, 1'b0, 32'h0000_3400, 8'h80, 1'b0);
      commit_up();
    end
    probe(8'h80, "sat_low");
    drive_up(1'b1, 32'h0000_3000, 1'b1, 32'h0000_3400, 8'h80, 1'b0);
    commit_up();
    probe(8'h80, "sat_low_inc");
    check_state("sat_state");
  endtask

  task automatic test_jal();
    int          bhr0;
    logic [31:0] upd0;
    bhr0 = bhr_m;
    upd0 = stat_u_m;
    drive_up(1'b0, 32'h0000_0200, 1'b1, 32'h0000_0400, 8'h55, 1'b0);
    commit_up();
    n_checks++;
    if (bhr_out !== 8'(bhr0) || stat_updates !== upd0 + 32'd1) begin
      n_errors++;
      $display("FAIL jal_state: got bhr=%h upd=%0d, expected bhr=%h upd=%0d",
               bhr_out, stat_updates, 8'(bhr0), upd0 + 32'd1);
    end
    check_lookup(32'h0000_0200, "jal_lookup");
    n_checks++;
    if (lk_hit !== 1'b1) begin
      n_errors++;
      $display("FAIL jal_hit: got %b, expected 1", lk_hit);
    end
    probe(8'h55, "jal_pt_untouched");
  endtask

  task automatic test_same_cycle();
    logic [31:0] pc;
    pc = pc_for_idx(8'h9A, 22'h15);
    drive_up(1'b0, pc, 1'b1, 32'h0000_5000, 0, 1'b0);
    commit_up();
    drive_up(1'b1, 32'h0000_7000, 1'b1, 32'h0000_7100, 8'h9A, 1'b0);
    check_lookup(pc, "same_cycle_old");
    n_checks++;
    if (lk_taken !== 1'b0) begin
      n_errors++;
      $display("FAIL same_cycle_old_taken: got %b, expected 0", lk_taken);
    end
    commit_up();
    pc = pc_for_idx(8'h9A, 22'h16);
    drive_up(1'b0, pc, 1'b1, 32'h0000_6000, 0, 1'b0);
    commit_up();
    check_lookup(pc, "same_cycle_new");
    n_checks++;
    if (lk_taken !== 1'b1 || lk_target !== 32'h0000_6000) begin
      n_errors++;
      $display("FAIL same_cycle_new_taken: got taken=%b tgt=%h, expected taken=1 tgt=00006000",
               lk_taken, lk_target);
    end
  endtask

  task automatic test_random();
    logic [31:0] pc;
    int          idx;
    for (int it = 0; it < 300; it++) begin
      pc = 32'h0000_1000 | (32'($urandom_range(0, 15)) << 2) | (32'($urandom_range(0, 3)) << 12);
      check_lookup(pc, "rand_lookup");
      if ($urandom_range(0, 3) != 0) begin
        idx = int'((pc >> 2) & 32'hFF) ^ bhr_m;
        drive_up($urandom_range(0, 3) != 0, pc, 1'($urandom_range(0, 1)),
                 32'($urandom) & 32'hFFFF_FFFC, idx, 1'($urandom_range(0, 1)));
        commit_up();
      end else begin
        tick();
      end
    end
    check_state("rand_state");
  endtask

  task automatic test_init_restart();
    int cnt;
    reset = 1'b1;
    tick();
    model_reset();
    reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      drive_up(1'b1, 32'h0000_0200, 1'b1, 32'h0000_999C, $urandom_range(0, 255), 1'b1);
      commit_up();
    end
    check_lookup(32'h0000_0200, "restart_init_lookup");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wait_ready(cnt, 1'b1);
    n_checks++;
    if (cnt != 256) begin
      n_errors++;
      $display("FAIL restart_cycles: got %0d, expected 256", cnt);
    end
    ready_m = 1'b1;
    check_state("restart_state");
    check_lookup(32'h0000_0200, "restart_btb_clear");
    tick();
    probe(8'h40, "restart_pt_clear");
  endtask

  initial begin
    reset      = 1'b1;
    lk_pc      = '0;
    up_valid   = 1'b0;
    up_is_cond = 1'b0;
    up_pc      = '0;
    up_taken   = 1'b0;
    up_target  = '0;
    up_pt_idx  = '0;
    up_btb_idx = '0;
    up_mispred = 1'b0;
    test_reset();
    test_taken_branch();
    test_saturation();
    test_jal();
    test_same_cycle();
    test_random();
    test_init_restart();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
